// File: rtl/sphere_pkg.sv
// Shared types for the sphere-collision scheduler: job/result layouts, FSM states, FP32 zero.
// Pure declarations; no latency, no flow control.
package sphere_pkg;

  typedef struct packed {
    logic [31:0] x1;
    logic [31:0] y1;
    logic [31:0] z1;
    logic [31:0] r1;
    logic [31:0] x2;
    logic [31:0] y2;
    logic [31:0] z2;
    logic [31:0] r2;
  } sphere_job_t;

  typedef struct packed {
    logic [31:0] cx;
    logic [31:0] cy;
    logic [31:0] cz;
    logic [31:0] nx;
    logic [31:0] ny;
    logic [31:0] nz;
    logic [31:0] depth;
  } collide_res_t;

  typedef enum logic [2:0] {IDLE, ARB, RSTENG, RUN, RESP} sched_state_t;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  localparam collide_res_t RES_ZERO = '{default: FP32_ZERO};

endpackage

// File: rtl/sphere_collide_sched_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping; purely combinational.
// Zero latency; no backpressure of its own, the caller decides when the grant is used.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_any
);

  int j;

  // Walk offsets from farthest to nearest so the nearest hit is the one left standing.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    j         = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N_REQ;
      if (req[j]) begin
        grant     = N_REQ'(1) << j;
        grant_idx = ID_W'(j);
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sphere_collide_sched.sv
// Shares one sphere-collision engine among N_REQ requesters; latency ARB + RST_CYC + engine + 1.
// No new grant while a response waits on rsp_ready; rsp_* held stable until accepted.
module sphere_collide_sched
  import sphere_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int RST_CYC = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                 CLK_d,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*256-1:0] req_job,
  output logic                 eng_rst_n,
  output logic [255:0]         eng_job,
  input  logic                 eng_done,
  input  logic                 eng_ret,
  input  logic [223:0]         eng_res,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_ret,
  output logic [223:0]         rsp_res,
  output logic                 rsp_tmo,
  output logic                 busy
);

  localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  sched_state_t     state, state_nx;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_idx;
  logic [N_REQ-1:0] grant;
  logic             grant_any;
  logic [RC_W-1:0]  rst_cnt;
  logic [15:0]      wd_cnt;
  logic             wd_hit;
  sphere_job_t      job_sel;
  sphere_job_t      job_q;
  collide_res_t     res_q;
  logic [ID_W-1:0]  id_q;
  logic             ret_q;
  logic             tmo_q;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign job_sel = req_job[int'(grant_idx)*256 +: 256];
  assign wd_hit  = (wd_cnt == 16'(TIMEOUT));

  always_ff @(posedge CLK_d or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req_valid) state_nx = ARB;
      ARB:     state_nx = grant_any ? RSTENG : IDLE;
      RSTENG:  if (rst_cnt == '0) state_nx = RUN;
      RUN:     if (eng_done || wd_hit) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = (|req_valid) ? ARB : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Engine only leaves reset in RUN, so it is parked while a response waits.
  always_comb begin
    req_ready = (state == ARB) ? grant : '0;
    eng_rst_n = (state == RUN);
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  always_ff @(posedge CLK_d or negedge rst) begin
    if (!rst) begin
      rr_ptr  <= '0;
      job_q   <= '0;
      id_q    <= '0;
      ret_q   <= 1'b0;
      res_q   <= RES_ZERO;
      tmo_q   <= 1'b0;
      rst_cnt <= '0;
      wd_cnt  <= '0;
    end else begin
      case (state)
        ARB: begin
          if (grant_any) begin
            job_q   <= job_sel;
            id_q    <= grant_idx;
            rr_ptr  <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            rst_cnt <= RC_W'(RST_CYC - 1);
            wd_cnt  <= '0;
          end
        end
        RSTENG: begin
          if (rst_cnt != '0) rst_cnt <= rst_cnt - 1'b1;
        end
        RUN: begin
          // A done arriving on the watchdog's last cycle still counts as a real result.
          if (eng_done) begin
            ret_q <= eng_ret;
            res_q <= eng_res;
            tmo_q <= 1'b0;
          end else if (wd_hit) begin
            ret_q <= 1'b0;
            res_q <= RES_ZERO;
            tmo_q <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign eng_job = job_q;
  assign rsp_id  = id_q;
  assign rsp_ret = ret_q;
  assign rsp_res = res_q;
  assign rsp_tmo = tmo_q;

endmodule

// File: tb/tb_sphere_collide_sched.sv
// Randomized bench for sphere_collide_sched: stub engine, requester drivers, scoreboard monitor.
module tb_sphere_collide_sched;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int RC  = 2;
  localparam int TMO = 1023;

  logic             CLK_d = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*256-1:0] req_job;
  logic             eng_rst_n;
  logic [255:0]     eng_job;
  logic             eng_done;
  logic             eng_ret;
  logic [223:0]     eng_res;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic             rsp_ret;
  logic [223:0]     rsp_res;
  logic             rsp_tmo;
  logic             busy;

  sphere_collide_sched #(.N_REQ(N), .ID_W(IDW), .RST_CYC(RC), .TIMEOUT(TMO)) dut (
    .CLK_d     (CLK_d),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_job   (req_job),
    .eng_rst_n (eng_rst_n),
    .eng_job   (eng_job),
    .eng_done  (eng_done),
    .eng_ret   (eng_ret),
    .eng_res   (eng_res),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_ret   (rsp_ret),
    .rsp_res   (rsp_res),
    .rsp_tmo   (rsp_tmo),
    .busy      (busy)
  );

  always #5 CLK_d = ~CLK_d;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Stub engine: job low 12 bits give its run length, the rest derive the answer.
  function automatic logic exp_ret(input logic [255:0] j);
    return j[12] ^ j[200];
  endfunction

  function automatic logic [223:0] exp_res(input logic [255:0] j);
    return j[255:32] ^ {7{32'h5A5A_C3C3}};
  endfunction

  int           eng_cnt;
  logic         run_prev;
  logic         glitch;
  logic [223:0] noise;

  initial begin
    eng_cnt = 0; run_prev = 1'b0; glitch = 1'b0; noise = '0;
    forever begin
      @(posedge CLK_d); #1;
      eng_cnt  = run_prev ? eng_cnt + 1 : 0;
      run_prev = eng_rst_n;
      glitch   = 1'($urandom_range(1));
      for (int k = 0; k < 7; k++) noise[k*32 +: 32] = $urandom;
    end
  end

  assign eng_done = eng_rst_n ? (eng_cnt >= int'(eng_job[11:0])) : glitch;
  assign eng_ret  = eng_rst_n ? exp_ret(eng_job) : glitch;
  assign eng_res  = (eng_rst_n && eng_done) ? exp_res(eng_job) : noise;

  // Requester drivers
  int           target[N] = '{default: 0};
  int           issued[N];
  int           hs_seen[N];
  int           hs_cnt[N];
  int           lat_min, lat_max, rdy_mode;
  logic [255:0] jobs[N];

  for (genvar g = 0; g < N; g++) begin : g_job
    assign req_job[g*256 +: 256] = jobs[g];
  end

  function automatic logic [255:0] new_job();
    logic [255:0] j;
    for (int k = 0; k < 8; k++) j[k*32 +: 32] = $urandom;
    j[11:0] = 12'($urandom_range(lat_max, lat_min));
    return j;
  endfunction

  initial begin
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      jobs[i] = '0; issued[i] = 0; hs_seen[i] = 0;
    end
    forever begin
      @(posedge CLK_d); #1;
      for (int i = 0; i < N; i++) begin
        if (!rst) begin
          req_valid[i] = 1'b0;
          hs_seen[i]   = hs_cnt[i];
        end else begin
          if (hs_cnt[i] != hs_seen[i]) begin
            hs_seen[i]   = hs_cnt[i];
            req_valid[i] = 1'b0;
          end
          if (!req_valid[i] && issued[i] < target[i]) begin
            jobs[i]      = new_job();
            req_valid[i] = 1'b1;
            issued[i]++;
          end
        end
      end
    end
  end

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge CLK_d); #1;
      case (rdy_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard and monitor
  typedef struct {
    int           id;
    logic         ret;
    logic [223:0] res;
    logic         tmo;
    int           delta;
    int           gcyc;
    logic [255:0] job;
  } exp_t;

  exp_t         sb[$];
  int           grant_log[$];
  int           cyc = 0;
  int           ptr_m = 0;
  logic         pend = 1'b0;
  logic         expect_arb = 1'b0;
  logic         run_seen = 1'b0;
  logic [227:0] hold;

  function automatic int model_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  initial begin
    for (int i = 0; i < N; i++) hs_cnt[i] = 0;
    forever begin
      @(negedge CLK_d);
      cyc++;
      if (!rst) begin
        sb.delete(); ptr_m = 0; pend = 1'b0; expect_arb = 1'b0; run_seen = 1'b0;
        continue;
      end
      if (expect_arb) begin
        check("b2b_arb", req_ready != '0, 1'b1);
        expect_arb = 1'b0;
      end
      if (pend) check("no_grant_in_resp", req_ready, '0);
      if (req_ready != '0) begin
        int g;
        g = model_grant(req_valid, ptr_m);
        for (int i = N - 1; i >= 0; i--) if (req_ready[i]) hs_cnt[i]++;
        if (g < 0) begin
          check("spurious_grant", req_ready, '0);
        end else begin
          exp_t e;
          logic [255:0] j;
          int lat;
          check("grant", req_ready, N'(1) << g);
          j       = jobs[g];
          lat     = int'(j[11:0]);
          e.id    = g;
          e.tmo   = lat > TMO;
          e.ret   = e.tmo ? 1'b0 : exp_ret(j);
          e.res   = e.tmo ? '0 : exp_res(j);
          e.delta = RC + 2 + ((lat > TMO) ? TMO : lat);
          e.gcyc  = cyc;
          e.job   = j;
          sb.push_back(e);
          grant_log.push_back(g);
          ptr_m = (g + 1) % N;
        end
      end
      if (!eng_rst_n) run_seen = 1'b0;
      else if (!run_seen) begin
        run_seen = 1'b1;
        if (sb.size() == 0) check("run_without_grant", eng_rst_n, 1'b0);
        else check("eng_job", eng_job, sb[0].job);
      end
      if (rsp_valid) begin
        if (!pend) begin
          pend = 1'b1;
          hold = {rsp_id, rsp_ret, rsp_tmo, rsp_res};
          if (sb.size() == 0) check("rsp_without_job", rsp_valid, 1'b0);
          else check("latency", cyc - sb[0].gcyc, sb[0].delta);
        end else begin
          check("rsp_stable", {rsp_id, rsp_ret, rsp_tmo, rsp_res}, hold);
        end
        if (rsp_ready) begin
          if (sb.size() != 0) begin
            check("rsp_id", rsp_id, sb[0].id);
            check("rsp_ret", rsp_ret, sb[0].ret);
            check("rsp_tmo", rsp_tmo, sb[0].tmo);
            check("rsp_res", rsp_res, sb[0].res);
            void'(sb.pop_front());
          end
          pend       = 1'b0;
          expect_arb = (req_valid != '0);
        end
      end
    end
  end

  function automatic bit all_issued();
    for (int i = 0; i < N; i++) if (issued[i] != target[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int budget, input string name);
    int t;
    bit done;
    t = 0; done = 1'b0;
    while (!done && t < budget) begin
      @(negedge CLK_d);
      t++;
      done = (sb.size() == 0) && !busy && (req_valid == '0) && all_issued();
    end
    check({name, "_drained"}, done, 1'b1);
  endtask

  task automatic wait_sig(input string name, input int budget, input bit want_rsp);
    int t;
    t = 0;
    while (!(want_rsp ? rsp_valid : eng_rst_n) && t < budget) begin
      @(negedge CLK_d);
      t++;
    end
    check(name, want_rsp ? rsp_valid : eng_rst_n, 1'b1);
  endtask

  int exp_seq[5] = '{0, 1, 2, 3, 0};
  int base;

  initial begin
    rst = 1'b0; lat_min = 0; lat_max = 0; rdy_mode = 0;
    repeat (3) @(posedge CLK_d);
    #2;
    check("rst_req_ready", req_ready, '0);
    check("rst_eng_rst_n", eng_rst_n, 1'b0);
    check("rst_eng_job", eng_job, '0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, '0);
    check("rst_rsp_ret", rsp_ret, 1'b0);
    check("rst_rsp_res", rsp_res, '0);
    check("rst_rsp_tmo", rsp_tmo, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge CLK_d);
    rst = 1'b1;
    repeat (2) @(negedge CLK_d);

    // All four contending from rr_ptr=0; requester 0 comes back for a second job
    lat_min = 5; lat_max = 10;
    base = grant_log.size();
    target[0] += 2; target[1] += 1; target[2] += 1; target[3] += 1;
    wait_idle(3000, "rr4");
    check("rr4_count", grant_log.size() - base, 5);
    for (int k = 0; k < 5; k++)
      if (base + k < grant_log.size()) check("rr4_order", grant_log[base + k], exp_seq[k]);

    // Single job on requester 1, 43 cycles ARB to response
    lat_min = 39; lat_max = 39;
    base = grant_log.size();
    target[1] += 1;
    wait_idle(500, "single");
    if (base < grant_log.size()) check("single_grant", grant_log[base], 1);
    else check("single_grant", grant_log.size(), base + 1);

    // Engine that never finishes, then one finishing on the watchdog's last cycle
    lat_min = 4000; lat_max = 4000;
    target[3] += 1;
    wait_idle(2000, "timeout");
    lat_min = TMO; lat_max = TMO;
    target[0] += 1;
    wait_idle(2000, "done_at_tmo");

    // Response held off for 20 cycles while another requester waits
    rdy_mode = 2; lat_min = 3; lat_max = 6;
    target[0] += 1; target[2] += 1;
    wait_sig("bp_rsp_seen", 200, 1'b1);
    repeat (20) @(posedge CLK_d);
    #1 rdy_mode = 0;
    wait_idle(500, "backpressure");

    // Random traffic with random response acceptance
    rdy_mode = 1; lat_min = 0; lat_max = 40;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) target[i] += $urandom_range(3);
      wait_idle(5000, "random");
    end

    // Reset in RUN, then a fresh arbitration must start from index 0
    rdy_mode = 0; lat_min = 500; lat_max = 500;
    target[2] += 1;
    wait_sig("run_reached", 100, 1'b0);
    repeat (10) @(posedge CLK_d);
    #3 rst = 1'b0;
    #1;
    check("arst_eng_rst_n", eng_rst_n, 1'b0);
    check("arst_rsp_valid", rsp_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    for (int i = 0; i < N; i++) target[i] = issued[i];
    repeat (3) @(posedge CLK_d);
    @(negedge CLK_d);
    rst = 1'b1;
    lat_min = 5; lat_max = 5;
    base = grant_log.size();
    target[3] += 1; target[0] += 1;
    wait_idle(500, "post_rst");
    check("post_rst_count", grant_log.size() - base, 2);
    if (base + 1 < grant_log.size()) begin
      check("post_rst_first", grant_log[base], 0);
      check("post_rst_second", grant_log[base + 1], 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got still running want finished");
    $fatal(1, "simulation time limit");
  end

endmodule
